lr_predictor: RTL
=================

Name: lr_predictor

Overview:
- Consumer of the regression coefficients B0/B1 produced by the linear-regression datapath.
- Latches B0/B1, then streams (x, y) samples through a valid/ready handshake and computes y_hat = B0 + B1*x and residual = y - y_hat for each sample.
- Accumulates the sum of squared errors (SSE) over N_SAMPLES samples and flags completion.
- Uses the same signed Q10.10 fixed-point format as the datapath.

Parameters:
WIDTH, 20, sample/coefficient width, signed two's complement
FRAC, 10, fractional bits (Q10.10)
N_SAMPLES, 150, samples per run
CNT_W, 8, sample counter width (must hold N_SAMPLES)
SSE_W, 64, SSE accumulator width

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a run; honoured in IDLE and DONE only
inB0  input  WIDTH  intercept, Q10.10, sampled on accepted start
inB1  input  WIDTH  slope, Q10.10, sampled on accepted start
in_valid  input  1  inx/iny valid
in_ready  output  1  block can accept a sample
inx  input  WIDTH  sample x, Q10.10
iny  input  WIDTH  sample y, Q10.10
out_valid  output  1  out_yhat/out_residual valid this cycle (1-cycle pulse per sample)
out_yhat  output  WIDTH  predicted y, Q10.10
out_residual  output  WIDTH  y - y_hat, Q10.10
sse  output  SSE_W  sum of squared residuals, Q(SSE_W-2*FRAC).(2*FRAC)
busy  output  1  high in RUN and DRAIN
done  output  1  high in DONE

Behaviour:
- Reset (synchronous, any state, including mid-run): state=IDLE; counter=0; coefficient registers=0; pipeline valids=0; all outputs 0 (in_ready, out_valid, out_yhat, out_residual, sse, busy, done). Samples in flight are discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on start=1: latch inB0/inB1, clear sse and counter.
- RUN:
  - in_ready = (counter < N_SAMPLES).
  - A sample is accepted on an edge with in_valid && in_ready; counter increments on acceptance.
  - After the N_SAMPLES-th acceptance, go to DRAIN; in_ready goes low the following cycle.
- DRAIN: wait until the pipeline is empty, i.e. the last sample's SSE update has been written, then go to DONE.
- DONE: done=1, with sse and the last out_* values held. start=1 re-latches coefficients, clears sse, and goes to RUN.
- start in RUN/DRAIN is ignored.
- Pipeline, with acceptance at edge k:
  - Stage 1, edge k: register prod = B1*x as a signed 2*WIDTH product, plus y.
  - Stage 2, edge k+1: y_hat = B0 + (prod >>> FRAC) (arithmetic shift, truncation toward -inf), resized to WIDTH; residual = y - y_hat, resized to WIDTH. Register both. out_valid is high for the cycle following edge k+1.
  - Stage 3, edge k+2: sse += sign-extended residual*residual (2*WIDTH bits, non-negative). sse has no saturation and wraps modulo 2^SSE_W.
  - Throughput 1 sample/cycle; back-to-back acceptances yield back-to-back out_valid.
- No output backpressure: out_valid is a pulse and the sink must take it.
- in_valid while in_ready=0 is ignored. inx/iny must be stable only on the acceptance edge.
- Width reduction to WIDTH bits follows SATURATE_EN (below).

Optional Feature:
- Macro: LR_PREDICTOR_SATURATE_EN.
- Defined: y_hat and residual clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1] (-524288..524287 at WIDTH=20) when the full-precision result exceeds range. The SSE uses the clamped residual.
- Undefined: the low WIDTH bits are kept (two's-complement wrap).

Test Plan:
- Basic prediction: start with B0=1024 (1.0), B1=2048 (2.0); send x=3072 (3.0), y=7680 (7.5) -> 2 cycles later out_valid=1, out_yhat=7168, out_residual=512; next cycle sse=262144.
- Full run: N_SAMPLES=150 samples back-to-back with in_valid held high -> in_ready low exactly after the 150th accept; 150 out_valid pulses; done=1 three cycles after the last accept; sse equals the reference-model sum.
- Handshake gaps: toggle in_valid randomly, and hold in_valid while in_ready=0 after 150 samples -> counter equals accepts only; no extra out_valid; outputs match the model.
- Negative/truncation: B0=0, B1=-1024 (-1.0), x=1 (1/1024), y=0 -> out_yhat=-1, out_residual=1; then B1=512, x=1 -> out_yhat=0 (floor).
- Overflow: B0=0, B1=262144 (256.0), x=4096 (4.0), y=0 -> SATURATE_EN defined: out_yhat=524287, out_residual=-524287; undefined: out_yhat=0, out_residual=0.
- Reset mid-run: assert reset after 50 accepts with samples in flight -> next cycle all outputs 0, state IDLE, no out_valid pulse; a new start runs a clean 150-sample pass.

Source files
------------

// File: rtl/lr_predictor_if.sv
// Sample/coefficient handshake and result bundle between the predictor and its host.
// The slave modport is the predictor's view; the master modport is the host/source side.
interface lr_predictor_if #(
  parameter int WIDTH = 20,
  parameter int SSE_W = 64
);
  logic             start;
  logic [WIDTH-1:0] inB0;
  logic [WIDTH-1:0] inB1;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] inx;
  logic [WIDTH-1:0] iny;
  logic             out_valid;
  logic [WIDTH-1:0] out_yhat;
  logic [WIDTH-1:0] out_residual;
  logic [SSE_W-1:0] sse;
  logic             busy;
  logic             done;

  modport slave (
    input  start, inB0, inB1, in_valid, inx, iny,
    output in_ready, out_valid, out_yhat, out_residual, sse, busy, done
  );

  modport master (
    output start, inB0, inB1, in_valid, inx, iny,
    input  in_ready, out_valid, out_yhat, out_residual, sse, busy, done
  );
endinterface

// File: rtl/lr_predictor.sv
// Q10.10 linear predictor: y_hat = B0 + B1*x, residual and SSE over N_SAMPLES; LR_PREDICTOR_SATURATE_EN clamps instead of wrapping.
// Latency: out_valid two edges after acceptance, SSE updated on the third, done one edge after the pipeline drains.
// Backpressure: in_ready low outside RUN and after N_SAMPLES accepts; outputs are unconditioned pulses.
module lr_predictor #(
  parameter int WIDTH     = 20,
  parameter int FRAC      = 10,
  parameter int N_SAMPLES = 150,
  parameter int CNT_W     = 8,
  parameter int SSE_W     = 64
) (
  input  logic           clk,
  input  logic           reset,
  lr_predictor_if.slave  bus
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int FULL_W = PROD_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic signed [WIDTH-1:0]   r_b0;
  logic signed [WIDTH-1:0]   r_b1;
  logic                      r_in_ready;
  logic                      r_busy;
  logic                      r_done;

  logic                      r_v1;
  logic signed [PROD_W-1:0]  r_prod;
  logic signed [WIDTH-1:0]   r_y;
  logic                      r_v2;
  logic signed [WIDTH-1:0]   r_yhat;
  logic signed [WIDTH-1:0]   r_res;
  logic [SSE_W-1:0]          r_sse;

  logic                      w_accept;
  logic                      w_start_ok;
  logic                      w_last;
  logic signed [PROD_W-1:0]  w_x_ext;
  logic signed [PROD_W-1:0]  w_b1_ext;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [PROD_W-1:0]  w_shift;
  logic signed [FULL_W-1:0]  w_yhat_full;
  logic signed [WIDTH-1:0]   w_yhat;
  logic signed [FULL_W-1:0]  w_res_full;
  logic signed [WIDTH-1:0]   w_res;
  logic signed [PROD_W-1:0]  w_res_ext;
  logic signed [PROD_W-1:0]  w_sq;

  // Narrow a full-precision result to WIDTH bits: clamp or two's-complement wrap.
  function automatic logic signed [WIDTH-1:0] f_fit(input logic signed [FULL_W-1:0] v);
`ifdef LR_PREDICTOR_SATURATE_EN
    logic [FULL_W-WIDTH:0] hi;
    hi = v[FULL_W-1:WIDTH-1];
    if (!((&hi) || !(|hi)))
      return v[FULL_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return v[WIDTH-1:0];
`else
    return v[WIDTH-1:0];
`endif
  endfunction

  assign w_accept   = bus.in_valid && r_in_ready;
  assign w_start_ok = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last     = (r_cnt == CNT_W'(N_SAMPLES - 1));

  assign w_x_ext     = {{WIDTH{bus.inx[WIDTH-1]}}, bus.inx};
  assign w_b1_ext    = {{WIDTH{r_b1[WIDTH-1]}}, r_b1};
  assign w_prod      = w_x_ext * w_b1_ext;

  // Arithmetic shift floors toward -inf, matching the datapath's fixed-point rounding.
  assign w_shift     = r_prod >>> FRAC;
  assign w_yhat_full = {{(FULL_W-WIDTH){r_b0[WIDTH-1]}}, r_b0} + {w_shift[PROD_W-1], w_shift};
  assign w_yhat      = f_fit(w_yhat_full);
  assign w_res_full  = {{(FULL_W-WIDTH){r_y[WIDTH-1]}}, r_y}
                     - {{(FULL_W-WIDTH){w_yhat[WIDTH-1]}}, w_yhat};
  assign w_res       = f_fit(w_res_full);

  assign w_res_ext   = {{WIDTH{r_res[WIDTH-1]}}, r_res};
  assign w_sq        = w_res_ext * w_res_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_b0       <= '0;
      r_b1       <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state    <= S_RUN;
            r_b0       <= bus.inB0;
            r_b1       <= bus.inB1;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          // Both stages empty means the final SSE update has already landed.
          if (!r_v1 && !r_v2) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1   <= 1'b0;
      r_prod <= '0;
      r_y    <= '0;
      r_v2   <= 1'b0;
      r_yhat <= '0;
      r_res  <= '0;
      r_sse  <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_prod <= w_prod;
        r_y    <= bus.iny;
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_yhat <= w_yhat;
        r_res  <= w_res;
      end
      if (w_start_ok)
        r_sse <= '0;
      else if (r_v2)
        r_sse <= r_sse + {{(SSE_W-PROD_W){w_sq[PROD_W-1]}}, w_sq};
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.out_valid    = r_v2;
  assign bus.out_yhat     = r_yhat;
  assign bus.out_residual = r_res;
  assign bus.sse          = r_sse;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;

endmodule
